// File: rtl/pc_flow_control.sv
// pc_flow_control: registered program-counter sequencer.
// Owns the PC and the n/z/v status flags, resolves the branch/jump ops,
// and fetches indirect targets from data memory over a req/ack handshake.
// The core is stalled while a fetch is outstanding, and a fetch that gets
// no ack within TIMEOUT cycles is abandoned.
module pc_flow_control #(
  parameter int              PC_W     = 32,
  parameter int              DIR_W    = 26,
  parameter logic [PC_W-1:0] RESET_PC = {PC_W{1'b0}},
  parameter int              TIMEOUT  = 15
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             op_valid,
  input  logic [2:0]       op,
  input  logic             flag_we,
  input  logic             n_in,
  input  logic             z_in,
  input  logic             v_in,
  input  logic [DIR_W-1:0] j_diraddr,
  output logic             mem_req,
  input  logic             mem_ack,
  input  logic [PC_W-1:0]  mem_data,
  output logic [PC_W-1:0]  pc,
  output logic             stall,
  output logic             link_we,
  output logic [PC_W-1:0]  link_data,
  output logic             n,
  output logic             z,
  output logic             v,
  output logic             err_timeout,
  output logic             err_illegal
);

  // The counter only has to reach TIMEOUT-1.
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  // Low bits of the PC replaced by a bz direct target (word address + byte
  // offset). When PC_W == DIR_W+2 the shift wraps to zero and the mask
  // becomes all ones, so the whole PC is replaced.
  localparam logic [PC_W-1:0] DIR_MASK =
    ({{(PC_W-1){1'b0}}, 1'b1} << (DIR_W + 2)) - {{(PC_W-1){1'b0}}, 1'b1};

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_t;

  state_t            state_r;
  state_t            state_nxt_s;
  logic [CNT_W-1:0]  cnt_r;
  logic [PC_W-1:0]   pc_r;
  logic [PC_W-1:0]   pc4_s;
  logic [PC_W-1:0]   direct_pc_s;
  logic              link_we_r;
  logic [PC_W-1:0]   link_data_r;
  logic              n_r;
  logic              z_r;
  logic              v_r;
  logic              err_timeout_r;
  logic              err_illegal_r;
  logic              op_fetch_s;
  logic              op_link_s;
  logic              op_direct_s;
  logic              op_illegal_s;
  logic              timeout_s;
  logic              wait_s;

  assign pc4_s       = pc_r + {{(PC_W-3){1'b0}}, 3'b100};
  assign direct_pc_s = (pc4_s & ~DIR_MASK) |
                       ({{(PC_W-DIR_W){1'b0}}, j_diraddr} << 2);
  assign timeout_s   = (cnt_r == CNT_W'(TIMEOUT - 1));

  // Decode the op in IDLE against the registered (pre-update) flags.
  always_comb begin
    op_fetch_s   = 1'b0;
    op_link_s    = 1'b0;
    op_direct_s  = 1'b0;
    op_illegal_s = 1'b0;
    if (op_valid) begin
      case (op)
        3'b001: op_fetch_s = n_r;
        3'b010: op_fetch_s = z_r;
        3'b011: op_direct_s = z_r;
        3'b100: op_fetch_s = 1'b1;
        3'b101: begin
          op_fetch_s = 1'b1;
          op_link_s  = 1'b1;
        end
        3'b110: begin
          op_fetch_s = 1'b1;
          op_link_s  = 1'b1;
        end
        3'b111: op_illegal_s = 1'b1;
        default: op_fetch_s = 1'b0;
      endcase
    end else begin
      op_fetch_s = 1'b0;
    end
  end

  // State register; reset overrides an outstanding fetch.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next state: enter WAIT on a fetching op, leave on ack or timeout.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (op_fetch_s) begin
          state_nxt_s = ST_WAIT;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (mem_ack || timeout_s) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_WAIT;
        end
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Outputs decoded from the state register: request and stall while waiting.
  always_comb begin
    wait_s = 1'b0;
    case (state_r)
      ST_IDLE: wait_s = 1'b0;
      ST_WAIT: wait_s = 1'b1;
      default: wait_s = 1'b0;
    endcase
  end

  assign mem_req = wait_s;
  assign stall   = wait_s;

  // PC, link, flag, error and wait-counter updates.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_r          <= RESET_PC;
      cnt_r         <= {CNT_W{1'b0}};
      link_we_r     <= 1'b0;
      link_data_r   <= {PC_W{1'b0}};
      n_r           <= 1'b0;
      z_r           <= 1'b0;
      v_r           <= 1'b0;
      err_timeout_r <= 1'b0;
      err_illegal_r <= 1'b0;
    end else begin
      link_we_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          cnt_r <= {CNT_W{1'b0}};
          if (flag_we) begin
            n_r <= n_in;
            z_r <= z_in;
            v_r <= v_in;
          end
          if (op_illegal_s) begin
            err_illegal_r <= 1'b1;
          end
          if (op_link_s) begin
            link_we_r   <= 1'b1;
            link_data_r <= pc4_s;
          end
          // A fetching op holds the PC until the target arrives.
          if (op_fetch_s) begin
            pc_r <= pc_r;
          end else if (op_direct_s) begin
            pc_r <= direct_pc_s;
          end else begin
            pc_r <= pc4_s;
          end
        end
        ST_WAIT: begin
          // pc_r still holds the branching instruction's PC here.
          if (mem_ack) begin
            pc_r  <= mem_data;
            cnt_r <= {CNT_W{1'b0}};
          end else if (timeout_s) begin
            pc_r          <= pc4_s;
            err_timeout_r <= 1'b1;
            cnt_r         <= {CNT_W{1'b0}};
          end else begin
            cnt_r <= cnt_r + CNT_W'(1'b1);
          end
        end
        default: begin
          cnt_r <= {CNT_W{1'b0}};
        end
      endcase
    end
  end

  assign pc          = pc_r;
  assign link_we     = link_we_r;
  assign link_data   = link_data_r;
  assign n           = n_r;
  assign z           = z_r;
  assign v           = v_r;
  assign err_timeout = err_timeout_r;
  assign err_illegal = err_illegal_r;

endmodule

// File: tb/tb_pc_flow_control.sv
// Bench for pc_flow_control: directed scenarios followed by random traffic,
// checked against a cycle-level behavioural model through a scoreboard.
module tb_pc_flow_control;

  localparam int          PC_W    = 32;
  localparam int          DIR_W   = 26;
  localparam int          TIMEOUT = 4;
  localparam logic [31:0] RST_PC  = 32'h0000_0100;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             op_valid = 1'b0;
  logic [2:0]       op = 3'b000;
  logic             flag_we = 1'b0;
  logic             n_in = 1'b0;
  logic             z_in = 1'b0;
  logic             v_in = 1'b0;
  logic [DIR_W-1:0] j_diraddr = '0;
  logic             mem_req;
  logic             mem_ack = 1'b0;
  logic [PC_W-1:0]  mem_data = '0;
  logic [PC_W-1:0]  pc;
  logic             stall;
  logic             link_we;
  logic [PC_W-1:0]  link_data;
  logic             n, z, v;
  logic             err_timeout;
  logic             err_illegal;

  pc_flow_control #(
    .PC_W(PC_W), .DIR_W(DIR_W), .RESET_PC(RST_PC), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .reset(reset), .op_valid(op_valid), .op(op), .flag_we(flag_we),
    .n_in(n_in), .z_in(z_in), .v_in(v_in), .j_diraddr(j_diraddr),
    .mem_req(mem_req), .mem_ack(mem_ack), .mem_data(mem_data), .pc(pc),
    .stall(stall), .link_we(link_we), .link_data(link_data),
    .n(n), .z(z), .v(v), .err_timeout(err_timeout), .err_illegal(err_illegal)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic        stall;
    logic [31:0] link_data;
    logic        link_we;
    logic        n, z, v, eto, eill;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad = 0;

  // Behavioural model state: architectural view of the sequencer.
  logic [31:0] m_pc = 32'h0;
  bit          m_wait = 1'b0;
  int          m_waited = 0;
  logic        m_lwe = 1'b0;
  logic [31:0] m_ldata = 32'h0;
  logic        m_n = 1'b0, m_z = 1'b0, m_v = 1'b0;
  logic        m_eto = 1'b0, m_eill = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock of stimulus: drive inputs, advance the model, queue the
  // expected post-edge outputs, then move to the next cycle.
  task automatic cyc(input bit rst, input bit ov, input logic [2:0] o,
                     input bit fwe, input bit ni, input bit zi, input bit vi,
                     input logic [25:0] dir, input bit ack, input logic [31:0] data);
    logic [31:0] pc4;
    bit          fetch;
    exp_t        e;
    reset = rst; op_valid = ov; op = o; flag_we = fwe;
    n_in = ni; z_in = zi; v_in = vi; j_diraddr = dir;
    mem_ack = ack; mem_data = data;
    if (rst) begin
      m_pc = RST_PC; m_wait = 1'b0; m_waited = 0; m_lwe = 1'b0; m_ldata = 32'h0;
      m_n = 1'b0; m_z = 1'b0; m_v = 1'b0; m_eto = 1'b0; m_eill = 1'b0;
    end else if (m_wait) begin
      m_lwe = 1'b0;
      m_waited++;
      if (ack) begin
        m_pc = data; m_wait = 1'b0;
      end else if (m_waited == TIMEOUT) begin
        m_pc = m_pc + 32'd4; m_eto = 1'b1; m_wait = 1'b0;
      end
    end else begin
      pc4   = m_pc + 32'd4;
      fetch = ov && ((o == 3'd1 && m_n) || (o == 3'd2 && m_z) || (o >= 3'd4 && o <= 3'd6));
      m_lwe = ov && (o == 3'd5 || o == 3'd6);
      if (m_lwe) m_ldata = pc4;
      if (ov && o == 3'd7) m_eill = 1'b1;
      if (fetch) begin
        m_wait = 1'b1; m_waited = 0;
      end else if (ov && o == 3'd3 && m_z) begin
        m_pc = {pc4[31:28], dir, 2'b00};
      end else begin
        m_pc = pc4;
      end
      if (fwe) begin
        m_n = ni; m_z = zi; m_v = vi;
      end
    end
    e.pc = m_pc; e.stall = m_wait; e.link_we = m_lwe; e.link_data = m_ldata;
    e.n = m_n; e.z = m_z; e.v = m_v; e.eto = m_eto; e.eill = m_eill;
    q.push_back(e);
    @(posedge clk);
    #2;
  endtask

  task automatic idle();
    cyc(0, 0, 3'd0, 0, 0, 0, 0, 26'd0, 0, 32'h0);
  endtask

  task automatic opc(input logic [2:0] o, input logic [25:0] dir);
    cyc(0, 1, o, 0, 0, 0, 0, dir, 0, 32'h0);
  endtask

  task automatic ackw(input logic [31:0] data);
    cyc(0, 0, 3'd0, 0, 0, 0, 0, 26'd0, 1, data);
  endtask

  task automatic setf(input bit ni, input bit zi, input bit vi);
    cyc(0, 0, 3'd0, 1, ni, zi, vi, 26'd0, 0, 32'h0);
  endtask

  // Monitor: every cycle after an edge, compare the DUT against the oldest
  // queued expectation.
  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("pc", pc, e.pc);
        chk("stall", {31'd0, stall}, {31'd0, e.stall});
        chk("mem_req", {31'd0, mem_req}, {31'd0, e.stall});
        chk("link_we", {31'd0, link_we}, {31'd0, e.link_we});
        chk("link_data", link_data, e.link_data);
        chk("flags", {29'd0, n, z, v}, {29'd0, e.n, e.z, e.v});
        chk("err_timeout", {31'd0, err_timeout}, {31'd0, e.eto});
        chk("err_illegal", {31'd0, err_illegal}, {31'd0, e.eill});
      end
    end
  end

  initial begin : driver
    bit          r_rst, r_ov, r_fwe, r_ack;
    logic [2:0]  r_op;
    logic [31:0] r_data;
    @(posedge clk);
    #2;
    // Reset and free-running increments.
    cyc(1, 0, 3'd0, 0, 0, 0, 0, 26'd0, 0, 32'h0);
    idle(); idle(); idle();
    // bz taken / not taken at 0x00400010.
    opc(3'd4, 26'd0); ackw(32'h0040_000C);
    setf(0, 1, 0);
    opc(3'd3, 26'h40);
    opc(3'd4, 26'd0); ackw(32'h0040_000C);
    setf(0, 0, 0);
    opc(3'd3, 26'h40);
    // jalm at 0x200, ack in third wait cycle.
    opc(3'd4, 26'd0); ackw(32'h0000_0200);
    opc(3'd5, 26'd0); idle(); idle(); ackw(32'h0000_8000);
    idle();
    // brz with simultaneous flag update uses the old z.
    cyc(0, 1, 3'd2, 1, 0, 1, 0, 26'd0, 0, 32'h0);
    opc(3'd2, 26'd0); ackw(32'h0000_3000);
    // bmn taken, then jspal.
    setf(1, 0, 1);
    opc(3'd1, 26'd0); ackw(32'h0000_4000);
    opc(3'd6, 26'd0); idle(); ackw(32'h0000_5000);
    // Illegal op.
    opc(3'd7, 26'd0);
    // jmor timeout, then a late ack in IDLE.
    opc(3'd4, 26'd0); idle(); idle(); idle(); idle();
    ackw(32'hDEAD_0000); idle();
    // Reset during WAIT_MEM with a coincident ack, then a stray ack.
    opc(3'd4, 26'd0); idle();
    cyc(1, 0, 3'd0, 0, 0, 0, 0, 26'd0, 1, 32'h1234_5678);
    ackw(32'h1234_5678);
    // PC wrap from 0xFFFFFFFC.
    opc(3'd4, 26'd0); ackw(32'hFFFF_FFFC); idle(); idle();

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      r_rst  = ($urandom_range(99) == 0);
      r_ov   = ($urandom_range(3) != 0);
      r_op   = 3'($urandom_range(7));
      r_fwe  = ($urandom_range(2) == 0);
      r_ack  = m_wait ? ($urandom_range(2) == 0) : ($urandom_range(5) == 0);
      r_data = ($urandom_range(7) == 0) ? 32'hFFFF_FFF8 : $urandom;
      cyc(r_rst, r_ov, r_op, r_fwe, 1'($urandom_range(1)), 1'($urandom_range(1)),
          1'($urandom_range(1)), 26'($urandom), r_ack, r_data);
    end
    idle();
    @(posedge clk);
    #3;
    chk("scoreboard_drained", q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pc_flow_control.md
Name: pc_flow_control

Overview:
Registered program-counter sequencer that replaces the combinational next-PC/branch selector of the single-cycle MIPS datapath. It owns the PC register and keeps the n/z/v status flags in registers. It resolves bmn/brz/bz/jmor/jalm/jspal and performs multi-cycle indirect-target fetches from data memory through a req/ack handshake. While a fetch is outstanding it stalls the core, and it detects memory timeouts.

Parameters:
PC_W, 32, width of PC, pc4 arithmetic and memory target data
DIR_W, 26, width of the bz direct-address field; PC_W >= DIR_W+2 required
RESET_PC, 0, PC value loaded on reset
TIMEOUT, 15, max cycles in WAIT_MEM before abort (>= 1)

Ports:
clk  in  1  system clock, all state updates on rising edge
reset  in  1  synchronous, active-high
op_valid  in  1  instruction in decode is valid this cycle
op  in  3  000 none, 001 bmn, 010 brz, 011 bz, 100 jmor, 101 jalm, 110 jspal, 111 reserved
flag_we  in  1  latch n_in/z_in/v_in into status flags
n_in, z_in, v_in  in  1 each  ALU status from the current instruction
j_diraddr  in  DIR_W  direct word address for bz
mem_req  out  1  indirect target fetch request
mem_ack  in  1  fetch data valid
mem_data  in  PC_W  fetched target address
pc  out  PC_W  current PC (registered)
stall  out  1  core must hold; high whenever state is WAIT_MEM
link_we  out  1  one-cycle pulse: write link register
link_data  out  PC_W  return address for jalm/jspal
n, z, v  out  1 each  registered status flags
err_timeout  out  1  sticky: memory fetch aborted
err_illegal  out  1  sticky: op 111 accepted

Behaviour:
- Reset (sync, takes priority over everything, including mid-WAIT_MEM): pc=RESET_PC; state=IDLE; mem_req=0; stall=0; link_we=0; link_data=0; n=z=v=0; err_timeout=err_illegal=0; wait counter=0. Any mem_ack arriving after reset is ignored.
- pc4 = pc + 4, modulo 2^PC_W; wraps from all-ones region to low addresses silently.
- Flags: on flag_we, n/z/v <= inputs next edge. Branch decisions use the registered flags as they stand at the op cycle. If flag_we and a branch op coincide, the branch uses the OLD flags.
- FSM states: IDLE, WAIT_MEM.
- IDLE, op_valid=0 or op=000: pc <= pc4.
- IDLE, op=111: pc <= pc4; err_illegal <= 1.
- IDLE, bz: z=1 -> pc <= {pc4[PC_W-1:DIR_W+2], j_diraddr, 2'b00}; z=0 -> pc <= pc4. Single cycle, no stall.
- IDLE, bmn with n=0, or brz with z=0: pc <= pc4, no fetch.
- IDLE, bmn with n=1, brz with z=1, jmor, jalm, or jspal: next edge state <= WAIT_MEM, mem_req <= 1, pc held, counter <= 0.
  - For jalm/jspal, the same edge sets link_we <= 1 for exactly one cycle and link_data <= pc4 of the branching instruction.
- WAIT_MEM: stall=1 and mem_req=1 combinationally from state. pc held. op_valid, op and flag_we are ignored.
  - mem_ack=1: pc <= mem_data (used as-is, no alignment); mem_req <= 0; state <= IDLE. A combinational ack is not required; ack in the first WAIT_MEM cycle gives a 2-cycle branch total.
  - mem_ack=0: counter++. If counter reaches TIMEOUT-1 without ack: pc <= pc4 of the held PC, err_timeout <= 1, state <= IDLE.
  - mem_ack and timeout on the same cycle: ack wins.
- mem_ack while IDLE is ignored.
- Sticky errors clear only on reset.

Test Plan:
1. Reset with RESET_PC=0x100, then 3 idle cycles -> pc = 0x100, 0x104, 0x108, 0x10C; all flags and errors 0.
2. flag_we with z_in=1, then bz with j_diraddr=0x000040 at pc=0x00400010 -> next pc=0x00000100, stall never asserted. Repeat with z=0 -> pc=0x00400014.
3. jalm at pc=0x200 with ack after 3 cycles and mem_data=0x8000 -> link_we pulses once with link_data=0x204; stall high 3 cycles; pc=0x8000 the edge after ack.
4. brz with flag_we and z_in=1 in the same cycle, while registered z=0 -> not taken, pc <= pc4, no mem_req; next cycle z=1.
5. jmor with no mem_ack and TIMEOUT=4 -> stall for 4 cycles, then pc = held pc + 4, err_timeout=1 and stays set. A late ack is ignored.
6. Assert reset during WAIT_MEM, then ack -> pc=RESET_PC, mem_req=0, state IDLE, ack ignored. Also check pc=0xFFFFFFFC with no op -> pc=0x00000000.
